// File: rtl/lanceur_de_multi.sv
// Multi-dice roller: N_DICE free-running odometer dice, sampled after a fixed
// roll animation; reports per-die results, sum, max and a completed-roll count.
module lanceur_de_multi #(
    parameter int unsigned N_DICE      = 2,
    parameter int unsigned VAL_W       = 7,
    parameter int unsigned SUM_W       = 10,
    parameter int unsigned ROLL_CYCLES = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                      ClkIn,
    input  logic                      Rst,
    input  logic                      BLancer,
    input  logic [VAL_W-1:0]          Faces,
    output logic                      Busy,
    output logic                      Rolling,
    output logic [N_DICE*VAL_W-1:0]   Live,
    output logic [N_DICE*VAL_W-1:0]   Results,
    output logic [SUM_W-1:0]          Sum,
    output logic [VAL_W-1:0]          Max,
    output logic                      Valid,
    output logic [CNT_W-1:0]          RollCount
);

    localparam int unsigned TMR_W = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;
    localparam int unsigned DIE_W = N_DICE * VAL_W;

    typedef enum logic [1:0] {IDLE, ROLL, DONE} state_t;

    state_t             state_q;
    logic [TMR_W-1:0]   tmr_q;
    logic [VAL_W-1:0]   faces_l_q;
    logic [DIE_W-1:0]   odo_q, odo_d;
    logic [DIE_W-1:0]   results_q;
    logic [SUM_W-1:0]   sum_q, sum_c;
    logic [VAL_W-1:0]   max_q, max_c;
    logic [VAL_W-1:0]   faces_c;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q, rolling_q, valid_q;
    logic               s1_q, s2_q, s3_q;
    logic               press_c;

    // Clamp the requested face count into 2..100.
    always_comb begin
        faces_c = Faces;
        if (Faces < VAL_W'(2)) begin
            faces_c = VAL_W'(2);
        end else if (Faces > VAL_W'(100)) begin
            faces_c = VAL_W'(100);
        end
    end

    // Odometer: die i advances only while every lower die sits at FacesL.
    always_comb begin : odo_next
        logic adv;
        odo_d = odo_q;
        adv   = 1'b1;
        for (int i = 0; i < int'(N_DICE); i++) begin
            if (odo_q[i*VAL_W +: VAL_W] > faces_l_q) begin
                odo_d[i*VAL_W +: VAL_W] = VAL_W'(1);
            end else if (adv) begin
                odo_d[i*VAL_W +: VAL_W] = (odo_q[i*VAL_W +: VAL_W] == faces_l_q)
                                          ? VAL_W'(1)
                                          : odo_q[i*VAL_W +: VAL_W] + VAL_W'(1);
            end
            adv = adv & (odo_q[i*VAL_W +: VAL_W] == faces_l_q);
        end
    end

    always_comb begin
        sum_c = '0;
        max_c = '0;
        for (int i = 0; i < int'(N_DICE); i++) begin
            sum_c = sum_c + SUM_W'(odo_q[i*VAL_W +: VAL_W]);
            if (odo_q[i*VAL_W +: VAL_W] > max_c) begin
                max_c = odo_q[i*VAL_W +: VAL_W];
            end
        end
    end

    assign press_c = s2_q & ~s3_q;

    always_ff @(posedge ClkIn or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            faces_l_q <= VAL_W'(2);
            odo_q     <= {N_DICE{VAL_W'(1)}};
            results_q <= '0;
            sum_q     <= '0;
            max_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            rolling_q <= 1'b0;
            valid_q   <= 1'b0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
        end else begin
            s1_q    <= BLancer;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            odo_q   <= odo_d;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    faces_l_q <= faces_c;
                    if (press_c) begin
                        state_q   <= ROLL;
                        tmr_q     <= TMR_W'(ROLL_CYCLES - 1);
                        busy_q    <= 1'b1;
                        rolling_q <= 1'b1;
                    end
                end
                ROLL: begin
                    if (tmr_q == '0) begin
                        results_q <= odo_q;
                        sum_q     <= sum_c;
                        max_q     <= max_c;
                        valid_q   <= 1'b1;
                        rolling_q <= 1'b0;
                        state_q   <= DONE;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                DONE: begin
                    cnt_q   <= cnt_q + CNT_W'(1);
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    rolling_q <= 1'b0;
                end
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Rolling   = rolling_q;
    assign Live      = odo_q;
    assign Results   = results_q;
    assign Sum       = sum_q;
    assign Max       = max_q;
    assign Valid     = valid_q;
    assign RollCount = cnt_q;

endmodule

// File: tb/tb_lanceur_de_multi.sv
// Bench for lanceur_de_multi: random launches and face changes against a
// cycle-level behavioural model, plus hand-computed literal expectations.
module tb_lanceur_de_multi;

    localparam int N  = 2;
    localparam int VW = 7;
    localparam int SW = 10;
    localparam int RC = 16;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            blancer;
    logic [VW-1:0]   faces;
    logic            busy, rolling, valid;
    logic [N*VW-1:0] live, results;
    logic [SW-1:0]   sum;
    logic [VW-1:0]   maxv;
    logic [CW-1:0]   rcount;

    int checks   = 0;
    int failures = 0;

    lanceur_de_multi #(.N_DICE(N), .VAL_W(VW), .SUM_W(SW), .ROLL_CYCLES(RC), .CNT_W(CW)) dut (
        .ClkIn(clk), .Rst(rst), .BLancer(blancer), .Faces(faces),
        .Busy(busy), .Rolling(rolling), .Live(live), .Results(results),
        .Sum(sum), .Max(maxv), .Valid(valid), .RollCount(rcount)
    );

    always #5 clk = ~clk;

    // Behavioural model: odometer values, latched faces, remaining roll clocks.
    int m_odo[N], n_odo[N], m_res[N];
    int m_fl, m_s1, m_s2, m_s3, m_left, m_done, m_sum, m_max, m_cnt, m_fc;
    bit m_top, m_press;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_odo[i] = 1;
                m_res[i] = 0;
            end
            m_fl = 2; m_s1 = 0; m_s2 = 0; m_s3 = 0;
            m_left = 0; m_done = 0; m_sum = 0; m_max = 0; m_cnt = 0;
        end else begin
            m_press = (m_s2 == 1) && (m_s3 == 0);
            m_fc = (int'(faces) < 2) ? 2 : (int'(faces) > 100) ? 100 : int'(faces);
            m_top = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (m_odo[i] > m_fl)  n_odo[i] = 1;
                else if (m_top)       n_odo[i] = (m_odo[i] == m_fl) ? 1 : m_odo[i] + 1;
                else                  n_odo[i] = m_odo[i];
                m_top = m_top && (m_odo[i] == m_fl);
            end
            if (m_done == 1) begin
                m_done = 0;
                m_cnt  = (m_cnt + 1) % 256;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_sum = 0; m_max = 0;
                    for (int i = 0; i < N; i++) begin
                        m_res[i] = m_odo[i];
                        m_sum += m_odo[i];
                        if (m_odo[i] > m_max) m_max = m_odo[i];
                    end
                    m_done = 1;
                end
            end else begin
                m_fl = m_fc;
                if (m_press) m_left = RC;
            end
            m_odo = n_odo;
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = int'(blancer);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            chk("live", int'(live[i*VW +: VW]), m_odo[i]);
            chk("results", int'(results[i*VW +: VW]), m_res[i]);
            if (valid)
                chk("res_in_range", int'(results[i*VW +: VW] >= 1 && int'(results[i*VW +: VW]) <= m_fl), 1);
        end
        chk("sum", int'(sum), m_sum);
        chk("max", int'(maxv), m_max);
        chk("valid", int'(valid), m_done);
        chk("busy", int'(busy), int'(m_left > 0 || m_done == 1));
        chk("rolling", int'(rolling), int'(m_left > 0));
        chk("rollcount", int'(rcount), m_cnt);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1);
            if (valid) seen = 1'b1;
        end
        chk("valid_timeout", int'(seen), 1);
    endtask

    task automatic one_roll();
        blancer = 1'b1;
        step(1);
        blancer = 1'b0;
        wait_valid(40);
        step(1);
    endtask

    int seq[7];
    int cnt, nvalid, prev, maxseen;
    bit found;

    initial begin
        rst = 1'b1; blancer = 1'b0; faces = 7'd6;
        step(3);
        rst = 1'b0;

        // Idle after reset: die0 counts 1..6 then wraps; nothing captured.
        seq = '{1, 2, 3, 4, 5, 6, 1};
        nvalid = 0;
        for (int i = 0; i < 7; i++) begin
            chk("lit_die0_seq", int'(live[VW-1:0]), seq[i]);
            if (valid) nvalid++;
            step(1);
        end
        chk("lit_idle_valids", nvalid, 0);
        chk("lit_reset_results", int'(results), 0);
        chk("lit_reset_sum", int'(sum), 0);

        // Single roll: Busy two clocks after synchroniser, 16 rolling clocks.
        blancer = 1'b1;
        step(1); chk("lit_busy_k", int'(busy), 0);
        step(1); chk("lit_busy_k1", int'(busy), 0);
        step(1); chk("lit_busy_k2", int'(busy), 1);
        blancer = 1'b0;
        cnt = 1; nvalid = 0;
        for (int i = 0; i < 40 && (rolling || !valid); i++) begin
            step(1);
            if (rolling) cnt++;
            if (valid) nvalid++;
        end
        chk("lit_roll_len", cnt, RC);
        chk("lit_one_valid", nvalid, 1);
        step(1);
        chk("lit_rollcount1", int'(rcount), 1);

        // Clamp: low faces, then 120 and 100 both wrap die0 at 100.
        faces = 7'd0; one_roll();
        faces = 7'd1; one_roll();
        for (int f = 0; f < 2; f++) begin
            faces = (f == 0) ? 7'd120 : 7'd100;
            step(1);
            found = 1'b0; maxseen = 0; prev = int'(live[VW-1:0]);
            for (int i = 0; i < 250 && !found; i++) begin
                step(1);
                if (int'(live[VW-1:0]) > maxseen) maxseen = int'(live[VW-1:0]);
                if (prev == 100 && live[VW-1:0] == 7'd1) found = 1'b1;
                prev = int'(live[VW-1:0]);
            end
            chk("lit_wrap100", int'(found), 1);
            chk("lit_max100", maxseen, 100);
        end

        // Extra pulses during ROLL, then a long hold: one Valid each.
        faces = 7'd6;
        blancer = 1'b1; step(1); blancer = 1'b0; step(3);
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            blancer = ~blancer; step(1);
        end
        blancer = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (valid) nvalid++;
            step(1);
        end
        chk("lit_pulses_one_valid", nvalid, 1);
        nvalid = 0;
        blancer = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (valid) nvalid++;
        end
        blancer = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (valid) nvalid++;
        end
        chk("lit_held_one_valid", nvalid, 1);

        // Reset at tmr==5: everything cleared at once, then a clean roll.
        blancer = 1'b1; step(1); blancer = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1);
            if (rolling) found = 1'b1;
        end
        chk("lit_roll_started", int'(found), 1);
        step(10);
        rst = 1'b1;
        #1;
        chk("lit_rst_busy", int'(busy), 0);
        chk("lit_rst_rolling", int'(rolling), 0);
        chk("lit_rst_results", int'(results), 0);
        chk("lit_rst_valid", int'(valid), 0);
        step(2);
        rst = 1'b0;
        one_roll();
        chk("lit_after_rst_count", int'(rcount), 1);

        // Face drop 8->4 while die0 climbs: out-of-range die reloads 1.
        faces = 7'd8; step(2);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (live[VW-1:0] == 7'd6) found = 1'b1;
            else step(1);
        end
        chk("lit_saw_six", int'(found), 1);
        faces = 7'd4;
        step(1); chk("lit_die0_7", int'(live[VW-1:0]), 7);
        step(1); chk("lit_die0_reload", int'(live[VW-1:0]), 1);

        // RollCount wrap.
        faces = 7'd6;
        for (int i = 0; i < 254; i++) one_roll();
        chk("lit_count255", int'(rcount), 255);
        one_roll();
        chk("lit_count_wrap", int'(rcount), 0);

        // Random launches, holds, gaps and face changes.
        for (int i = 0; i < 60; i++) begin
            faces = 7'($urandom_range(0, 127));
            step($urandom_range(0, 4));
            blancer = 1'b1;
            step($urandom_range(1, 25));
            if ($urandom_range(0, 3) == 0) faces = 7'($urandom_range(0, 127));
            blancer = 1'b0;
            step($urandom_range(1, 30));
        end
        step(25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
